// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// The sel/data widths must stay in step with the register file itself.
package regfile_writeback_arbiter_pkg;

  localparam int WB_NUM_REQ    = 4;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_NUM_REGS   = 16;
  localparam int WB_SEL_WIDTH  = $clog2(WB_NUM_REGS);

  // One writeback request: destination register and the value to write.
  typedef struct packed {
    logic [WB_SEL_WIDTH-1:0]  sel;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_writeback_arbiter_rr.sv
// Combinational round-robin arbiter.
// Requests at or above the pointer are searched first; if none of them is
// valid, the search wraps around to the lowest valid index.
module regfile_writeback_arbiter_rr #(
  parameter int NUM_REQ   = 4,
  parameter int PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [PTR_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   grant,
  output logic [PTR_WIDTH-1:0] grant_idx,
  output logic                 grant_any
);

  logic [NUM_REQ-1:0] upper_mask;
  logic [NUM_REQ-1:0] masked_req;
  logic [NUM_REQ-1:0] pick_from;

  // Thermometer mask selecting indices at or above the pointer.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
    assign upper_mask[gi] = (gi >= int'(ptr));
  end

  assign masked_req = req & upper_mask;
  assign pick_from  = (|masked_req) ? masked_req : req;
  // Isolate the lowest set bit of the chosen vector.
  assign grant      = pick_from & (~pick_from + NUM_REQ'(1));
  assign grant_any  = |req;

  // Encode the one-hot grant into an index for the data mux and pointer.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = PTR_WIDTH'(i);
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Shares the register file write port among several writeback units with
// round-robin arbitration, and tracks registers with an outstanding write
// so the issue stage can stall dependent reads.
module regfile_writeback_arbiter
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = WB_NUM_REQ,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int NUM_REGS   = WB_NUM_REGS,
  localparam int SEL_WIDTH = $clog2(NUM_REGS),
  localparam int PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  in_req_valid,
  input  logic [NUM_REQ-1:0][SEL_WIDTH-1:0]   in_req_sel,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  in_req_data,
  output logic [NUM_REQ-1:0]                  out_req_ready,
  input  logic                                in_claim_en,
  input  logic [SEL_WIDTH-1:0]                in_claim_sel,
  input  logic [SEL_WIDTH-1:0]                in_query_sel_ra,
  input  logic [SEL_WIDTH-1:0]                in_query_sel_rb,
  input  logic [SEL_WIDTH-1:0]                in_query_sel_rc,
  output logic                                out_stall,
  output logic                                out_write_en,
  output logic [SEL_WIDTH-1:0]                out_write_sel,
  output logic [DATA_WIDTH-1:0]               out_write_data
);

  logic [PTR_WIDTH-1:0]  rr_ptr_reg;
  logic [NUM_REQ-1:0]    grant;
  logic [PTR_WIDTH-1:0]  grant_idx;
  logic                  grant_any;
  logic [SEL_WIDTH-1:0]  granted_sel;
  logic [DATA_WIDTH-1:0] granted_data;

  logic                  write_en_reg;
  logic [SEL_WIDTH-1:0]  write_sel_reg;
  logic [DATA_WIDTH-1:0] write_data_reg;

  logic [NUM_REGS-1:0]   pending_reg;
  logic [NUM_REGS-1:0]   pending_next;

  regfile_writeback_arbiter_rr #(
    .NUM_REQ   (NUM_REQ),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_rr (
    .req       (in_req_valid),
    .ptr       (rr_ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Ready only ever goes to a valid requester, so a grant is always accepted.
  assign out_req_ready = grant;
  assign granted_sel   = in_req_sel[grant_idx];
  assign granted_data  = in_req_data[grant_idx];

  // Pointer and write-port register; a grant to r0 uses the slot but writes nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg     <= '0;
      write_en_reg   <= 1'b0;
      write_sel_reg  <= '0;
      write_data_reg <= '0;
    end else if (grant_any) begin
      rr_ptr_reg     <= (grant_idx == PTR_WIDTH'(NUM_REQ - 1)) ? '0
                                                               : grant_idx + PTR_WIDTH'(1);
      write_en_reg   <= (granted_sel != '0);
      write_sel_reg  <= granted_sel;
      write_data_reg <= granted_data;
    end else begin
      write_en_reg   <= 1'b0;
    end
  end

  // A write sitting in the output register during reset must not commit.
  assign out_write_en   = write_en_reg & ~rst;
  assign out_write_sel  = write_sel_reg;
  assign out_write_data = write_data_reg;

  // Scoreboard next state: clear on commit, then set on claim so a claim wins a collision.
  always_comb begin
    pending_next = pending_reg;
    if (write_en_reg) pending_next[write_sel_reg] = 1'b0;
    if (in_claim_en && (in_claim_sel != '0)) pending_next[in_claim_sel] = 1'b1;
    pending_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) pending_reg <= '0;
    else     pending_reg <= pending_next;
  end

  // No bypass: a register is readable the cycle after its pending bit clears.
  assign out_stall = pending_reg[in_query_sel_ra] |
                     pending_reg[in_query_sel_rb] |
                     pending_reg[in_query_sel_rc];

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Self-checking bench for regfile_writeback_arbiter: directed scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_regfile_writeback_arbiter;
  import regfile_writeback_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int NG = 16;
  localparam int SW = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NR-1:0]        valid;
  logic [NR-1:0][SW-1:0] req_sel;
  logic [NR-1:0][DW-1:0] req_data;
  logic [NR-1:0]        ready;
  logic                 claim_en;
  logic [SW-1:0]        claim_sel;
  logic [SW-1:0]        qa, qb, qc;
  logic                 stall;
  logic                 wen;
  logic [SW-1:0]        wsel;
  logic [DW-1:0]        wdata;

  always #5 clk = ~clk;

  regfile_writeback_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .in_req_valid    (valid),
    .in_req_sel      (req_sel),
    .in_req_data     (req_data),
    .out_req_ready   (ready),
    .in_claim_en     (claim_en),
    .in_claim_sel    (claim_sel),
    .in_query_sel_ra (qa),
    .in_query_sel_rb (qb),
    .in_query_sel_rc (qc),
    .out_stall       (stall),
    .out_write_en    (wen),
    .out_write_sel   (wsel),
    .out_write_data  (wdata)
  );

  // Behavioural model state
  int            m_ptr;
  logic [NG-1:0] m_pend;
  logic          m_wen;
  wb_req_t       m_wr;
  bit            m_live = 0;

  // Values seen on the DUT in the most recent cycle, for literal checks
  logic [NR-1:0] obs_ready;
  logic          obs_wen, obs_stall;
  logic [SW-1:0] obs_sel;
  logic [DW-1:0] obs_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First valid requester searching upward from the pointer, wrapping.
  function automatic int model_pick(input logic [NR-1:0] v, input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] onehot(input int idx);
    logic [NR-1:0] r;
    r = '0;
    if (idx >= 0) r[idx] = 1'b1;
    return r;
  endfunction

  // One clock cycle: inputs are already driven; compare mid-cycle, advance model.
  task automatic cycle();
    int g;
    logic [NG-1:0] p;
    #3;
    obs_ready = ready; obs_wen = wen; obs_stall = stall; obs_sel = wsel; obs_data = wdata;
    g = model_pick(valid, m_ptr);
    if (m_live) begin
      check("ready", 64'(ready), 64'(onehot(g)));
      check("write_en", 64'(wen), 64'(m_wen & ~rst));
      check("write_sel", 64'(wsel), 64'(m_wr.sel));
      check("write_data", 64'(wdata), 64'(m_wr.data));
      check("stall", 64'(stall), 64'(m_pend[qa] | m_pend[qb] | m_pend[qc]));
    end
    if (rst) begin
      m_ptr = 0; m_pend = '0; m_wen = 1'b0; m_wr = '0; m_live = 1;
    end else begin
      p = m_pend;
      if (m_wen) p[m_wr.sel] = 1'b0;
      if (claim_en && claim_sel != 0) p[claim_sel] = 1'b1;
      p[0] = 1'b0;
      if (g >= 0) begin
        m_ptr   = (g + 1) % NR;
        m_wen   = (req_sel[g] != 0);
        m_wr.sel  = req_sel[g];
        m_wr.data = req_data[g];
      end else begin
        m_wen = 1'b0;
      end
      m_pend = p;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid = '0; claim_en = 1'b0; claim_sel = '0;
    qa = '0; qb = '0; qc = '0;
    for (int i = 0; i < NR; i++) begin
      req_sel[i] = SW'(i + 1);
      req_data[i] = $urandom;
    end

    // Reset defaults: two reset cycles, then first request vector
    cycle();
    cycle();
    check("rst_write_en", 64'(obs_wen), 64'd0);
    check("rst_write_sel", 64'(obs_sel), 64'd0);
    check("rst_write_data", 64'(obs_data), 64'd0);
    check("rst_stall", 64'(obs_stall), 64'd0);
    rst = 1'b0; valid = 4'b0110;
    cycle();
    check("rst_first_grant", 64'(obs_ready), 64'(4'b0010));
    valid = '0;
    cycle();

    // Round-robin fairness from pointer 0
    rst = 1'b1;
    cycle();
    rst = 1'b0; valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("rr_grant", 64'(obs_ready), 64'(onehot(k % 4)));
      if (k > 0) begin
        check("rr_wen", 64'(obs_wen), 64'd1);
        check("rr_sel", 64'(obs_sel), 64'((k - 1) % 4 + 1));
      end
    end
    valid = '0;
    cycle();
    check("rr_last_sel", 64'(obs_sel), 64'd4);

    // r0 write: slot consumed, no write, pointer moves to 3
    valid = 4'b0100; req_sel[2] = '0; req_data[2] = 32'hDEADBEEF;
    cycle();
    check("r0_grant", 64'(obs_ready), 64'(4'b0100));
    valid = '0;
    cycle();
    check("r0_wen", 64'(obs_wen), 64'd0);
    check("r0_data", 64'(obs_data), 64'h0000_0000_DEAD_BEEF);
    valid = 4'b1111; req_sel[2] = 4'd3;
    cycle();
    check("r0_ptr_next", 64'(obs_ready), 64'(4'b1000));
    valid = '0;
    cycle();

    // Scoreboard latency on r5
    claim_en = 1'b1; claim_sel = 4'd5; qa = 4'd5;
    cycle();
    check("sb_c0_stall", 64'(obs_stall), 64'd0);
    claim_en = 1'b0;
    cycle();
    check("sb_c1_stall", 64'(obs_stall), 64'd1);
    cycle();
    valid = 4'b0010; req_sel[1] = 4'd5; req_data[1] = 32'h1234;
    cycle();
    check("sb_c3_grant", 64'(obs_ready), 64'(4'b0010));
    check("sb_c3_stall", 64'(obs_stall), 64'd1);
    valid = '0;
    cycle();
    check("sb_c4_wen", 64'(obs_wen), 64'd1);
    check("sb_c4_data", 64'(obs_data), 64'h1234);
    check("sb_c4_stall", 64'(obs_stall), 64'd1);
    cycle();
    check("sb_c5_stall", 64'(obs_stall), 64'd0);

    // Set/clear collision on r7
    claim_en = 1'b1; claim_sel = 4'd7; qa = 4'd7;
    cycle();
    claim_en = 1'b0; valid = 4'b0001; req_sel[0] = 4'd7;
    cycle();
    valid = '0; claim_en = 1'b1; claim_sel = 4'd7;
    cycle();
    check("col_wen", 64'(obs_wen), 64'd1);
    check("col_sel", 64'(obs_sel), 64'd7);
    claim_en = 1'b0;
    cycle();
    check("col_stall", 64'(obs_stall), 64'd1);
    cycle();
    check("col_stall2", 64'(obs_stall), 64'd1);

    // Reset mid-operation with r3 pending and three requesters valid
    claim_en = 1'b1; claim_sel = 4'd3; qa = 4'd3;
    cycle();
    claim_en = 1'b0; valid = 4'b0111;
    cycle();
    check("mid_stall_before", 64'(obs_stall), 64'd1);
    rst = 1'b1;
    cycle();
    check("mid_wen_in_rst", 64'(obs_wen), 64'd0);
    rst = 1'b0;
    cycle();
    check("mid_stall_after", 64'(obs_stall), 64'd0);
    check("mid_grant_after", 64'(obs_ready), 64'(4'b0001));
    check("mid_wen_after", 64'(obs_wen), 64'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      valid = NR'($urandom);
      for (int i = 0; i < NR; i++) begin
        req_sel[i]  = SW'($urandom);
        req_data[i] = $urandom;
      end
      claim_en  = $urandom_range(0, 2) != 0;
      claim_sel = SW'($urandom);
      qa = SW'($urandom); qb = SW'($urandom); qc = SW'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_arbiter.md
# regfile_writeback_arbiter

Shares the register file's single write port among `NUM_REQ` writeback requesters (ALU, multiplier, divider, load unit) using round-robin arbitration. It also keeps a pending-write scoreboard so issue logic can stall reads of registers that have an outstanding write. It sits between the execute/memory units and `RegisterFile`. It drives the register file's `write_en`, `write_sel` and `write_data` from registered outputs.

## Interface
- `NUM_REQ`, 4: number of writeback requesters; index 0 has highest priority out of reset.
- `DATA_WIDTH`, 32: register data width.
- `NUM_REGS`, 16: register count; the select width is `$clog2(NUM_REGS)`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_req_valid`  in  `NUM_REQ`  requester i has a writeback pending.
- `in_req_sel`  in  `NUM_REQ`×sel  destination register per requester.
- `in_req_data`  in  `NUM_REQ`×`DATA_WIDTH`  write data per requester.
- `out_req_ready`  out  `NUM_REQ`  one-hot grant; a request is accepted when valid and ready are both high.
- `in_claim_en`  in  1  issue stage claims a destination register this cycle.
- `in_claim_sel`  in  sel  register being claimed.
- `in_query_sel_ra`, `in_query_sel_rb`, `in_query_sel_rc`  in  sel each  issue-stage read selects.
- `out_stall`  out  1  at least one queried register is pending (combinational).
- `out_write_en`  out  1  to `RegisterFile` `write_en`.
- `out_write_sel`  out  sel  to `RegisterFile` `write_sel`.
- `out_write_data`  out  `DATA_WIDTH`  to `RegisterFile` `write_data`.

## Operation
- **Arbitration**
  - Combinational round-robin over `in_req_valid`, starting the search at pointer `rr_ptr`.
  - At most one bit of `out_req_ready` is high; it is all-zero when no requester is valid.
  - `out_req_ready` depends on `in_req_valid` and `rr_ptr` only, never on the requesters' `ready`.
- **Pointer update**
  - On an accepted grant to requester g, `rr_ptr` becomes (g+1) mod `NUM_REQ`.
  - With no grant, `rr_ptr` holds.
- **Write-port register**
  - On a grant, the output register loads `out_write_sel`/`out_write_data` from the granted requester.
  - `out_write_en` = 1 when the granted sel ≠ 0.
  - A grant to r0 consumes the slot but drives `out_write_en` = 0.
  - With no grant, `out_write_en` = 0. Sel and data hold their previous values.
- **Scoreboard**
  - `pending[NUM_REGS-1:0]`; bit 0 is always 0.
  - Set: `in_claim_en` with `in_claim_sel` ≠ 0.
  - Clear: `out_write_en` with `out_write_sel`, i.e. the cycle the register file commits the write.
  - Simultaneous set and clear of the same register: set wins.
  - Issue must not claim an already-pending register (it stalls on WAW). This guarantees at most one outstanding write per register. A re-claim leaves the bit set.
- **Stall**
  - `out_stall` = `pending[ra] | pending[rb] | pending[rc]`, evaluated on current register state.
  - There is no bypass, which matches the register file's synchronous, unbypassed reads.
- **Reset values**
  - `rr_ptr` = 0 and `pending` = 0.
  - `out_write_en` = 0, `out_write_sel` = 0, `out_write_data` = 0.
  - `out_req_ready` is therefore a pure function of `in_req_valid`, with requester 0 first.
  - `out_stall` = 0.
- **Reset mid-operation**: in-flight grants are discarded, a registered write in the reset cycle is suppressed, and all pending bits are cleared.

## Timing
- Request accepted in cycle N → `out_write_en` high in N+1 → register file updated at the end of N+1.
- The pending bit clears at that same edge, so `out_stall` for that register drops in N+2.
- A read issued in N+2 returns the new data.
- Claim in cycle C → pending visible (stall) from C+1.
- Throughput: one writeback per cycle.
- Under continuous contention, each valid requester waits at most `NUM_REQ`-1 grants.

## Structure
- Shared package `PkgRegFileArbiter` holds:
  - the sel/data width constants (shared with `PkgRegisterFile`);
  - `NUM_REQ`;
  - a `WbReq` struct {sel, data}.
- One sub-module, `RoundRobinArbiter`: a combinational grant computed from the request vector and the pointer.
- This module owns the pointer register, the write-port register and the scoreboard.

## Test plan
- **Reset defaults**: assert `rst` for 2 cycles → all outputs 0; `in_req_valid` = 4'b0110 then gives `out_req_ready` = 4'b0010.
- **Round-robin fairness**: `in_req_valid` = 4'b1111 held for 8 cycles → grants 0,1,2,3,0,1,2,3; each `out_write_en` lands 1 cycle after its grant with the matching sel/data.
- **r0 write**: requester 2 alone, sel = 0, data = 32'hDEADBEEF → ready[2] = 1; next cycle `out_write_en` = 0; `rr_ptr` advances to 3.
- **Scoreboard latency**
  - Claim r5 in cycle 0; query ra = 5 → `out_stall` = 1 from cycle 1.
  - Requester 1 writes r5 with 32'h1234 in cycle 3 → `out_write_en` in cycle 4, `out_stall` = 0 in cycle 5.
- **Set/clear collision**: the cycle r7's write commits, also claim r7 → r7 stays pending and `out_stall` stays 1 for query r7.
- **Reset mid-operation**: with r3 pending and 3 requesters valid, assert `rst` for 1 cycle → `pending` = 0, `out_write_en` = 0 next cycle, and requester 0 is granted first afterward.
